mmio_master: RTL

//  Bus initiator for the word-addressed memory-mapped I/O bus (re/rd/we/wd/addr[31:2]).

---
 rtl/mmio_master_pkg.sv | 41 ++++
 rtl/mmio_master_if.sv | 35 +++
 rtl/mmio_master_byte_lane_unit.sv | 62 ++++++
 rtl/mmio_master.sv | 135 +++++++++++++
 4 files changed

// File: rtl/mmio_master_pkg.sv
// Shared types and helpers for the MMIO bus initiator (package mmio_pkg).
package mmio_pkg;

  typedef enum logic [1:0] {
    SIZE_B = 2'b00,
    SIZE_H = 2'b01,
    SIZE_W = 2'b10
  } size_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    READ   = 3'd1,
    RMW_RD = 3'd2,
    WRITE  = 3'd3,
    RESP   = 3'd4
  } state_t;

  // Encoding 2'b11 is treated as a word access.
  function automatic size_t norm_size(logic [1:0] raw);
    return (raw == 2'b11) ? SIZE_W : size_t'(raw);
  endfunction

  // Half needs addr[0]=0, word needs addr[1:0]=0, byte is always aligned.
  function automatic logic is_misaligned(size_t size, logic [1:0] lo);
    case (size)
      SIZE_H:  return lo[0];
      SIZE_W:  return |lo;
      default: return 1'b0;
    endcase
  endfunction

  // Clears the low address bits that the access size cannot use.
  function automatic logic [1:0] align_lo(size_t size, logic [1:0] lo);
    case (size)
      SIZE_H:  return {lo[1], 1'b0};
      SIZE_W:  return 2'b00;
      default: return lo;
    endcase
  endfunction

endpackage

// File: rtl/mmio_master_if.sv
// LSU request/response handshake plus word-addressed MMIO bus, bundled for mmio_master.
interface mmio_master_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [1:0]            req_size;
  logic                  req_unsigned;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [31:0]           req_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [31:0]           rsp_rdata;
  logic                  rsp_err;
  logic                  bus_re;
  logic [31:0]           bus_rd;
  logic                  bus_we;
  logic [31:0]           bus_wd;
  logic [ADDR_WIDTH-3:0] bus_addr;

  modport master (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  rsp_ready, bus_rd,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output bus_re, bus_we, bus_wd, bus_addr
  );

  modport slave (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output rsp_ready, bus_rd,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  bus_re, bus_we, bus_wd, bus_addr
  );
endinterface

// File: rtl/mmio_master_byte_lane_unit.sv
// Combinational lane logic: extracts and extends sub-word load data, and merges
// sub-word store data into a word read back from the responder.
module byte_lane_unit
  import mmio_pkg::*;
(
  input  size_t       size,
  input  logic [1:0]  lane,
  input  logic        is_unsigned,
  input  logic [31:0] rd_word,
  input  logic [15:0] st_data,
  output logic [31:0] ld_data,
  output logic [31:0] merged
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  // Pick the addressed byte and half-word out of the read word.
  always_comb begin
    sel_byte = rd_word[7:0];
    case (lane)
      2'd0: sel_byte = rd_word[7:0];
      2'd1: sel_byte = rd_word[15:8];
      2'd2: sel_byte = rd_word[23:16];
      2'd3: sel_byte = rd_word[31:24];
      default: sel_byte = rd_word[7:0];
    endcase
    sel_half = lane[1] ? rd_word[31:16] : rd_word[15:0];
  end

  // Zero- or sign-extend the selected lane into a right-aligned load result.
  always_comb begin
    ld_data = rd_word;
    case (size)
      SIZE_B:  ld_data = is_unsigned ? {24'd0, sel_byte} : {{24{sel_byte[7]}}, sel_byte};
      SIZE_H:  ld_data = is_unsigned ? {16'd0, sel_half} : {{16{sel_half[15]}}, sel_half};
      default: ld_data = rd_word;
    endcase
  end

  // Overwrite only the addressed lane(s) of the read word with the store data.
  always_comb begin
    merged = rd_word;
    case (size)
      SIZE_B: begin
        case (lane)
          2'd0: merged[7:0]   = st_data[7:0];
          2'd1: merged[15:8]  = st_data[7:0];
          2'd2: merged[23:16] = st_data[7:0];
          2'd3: merged[31:24] = st_data[7:0];
          default: merged = rd_word;
        endcase
      end
      SIZE_H: begin
        if (lane[1]) merged[31:16] = st_data;
        else         merged[15:0]  = st_data;
      end
      default: merged = rd_word;
    endcase
  end

endmodule

// File: rtl/mmio_master.sv
// MMIO bus initiator: turns byte/half/word LSU requests into word-only bus
// reads/writes, with read-modify-write for sub-word stores.
// Optional macro MMIO_MASTER_MISALIGN_TRAP_EN: misaligned requests complete with
// rsp_err=1 and ERR_RDATA and no bus traffic; otherwise low address bits are
// forced to alignment and the access proceeds.
module mmio_master
  import mmio_pkg::*;
#(
  parameter int          ADDR_WIDTH = 32,
  parameter logic [31:0] ERR_RDATA  = 32'hDEAD_BEEF
) (
  input  logic          clk,
  input  logic          reset,
  mmio_master_if.master mif
);

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] addr_q;
  size_t                 size_q;
  logic                  uns_q;
  logic [15:0]           wdata_q;
  logic [31:0]           rdata_q;
  logic [31:0]           wd_q;
  logic [31:0]           ld_data;
  logic [31:0]           merged;
  size_t                 req_size_n;
  logic [ADDR_WIDTH-1:0] req_addr_eff;

  assign req_size_n = norm_size(mif.req_size);

`ifdef MMIO_MASTER_MISALIGN_TRAP_EN
  logic misaligned;
  logic err_q;
  assign misaligned   = is_misaligned(req_size_n, mif.req_addr[1:0]);
  assign req_addr_eff = mif.req_addr;
  assign mif.rsp_err  = err_q;
`else
  assign req_addr_eff = {mif.req_addr[ADDR_WIDTH-1:2], align_lo(req_size_n, mif.req_addr[1:0])};
  assign mif.rsp_err  = 1'b0;
`endif

  assign mif.rsp_rdata = rdata_q;
  assign mif.bus_wd    = wd_q;

  byte_lane_unit u_lanes (
    .size        (size_q),
    .lane        (addr_q[1:0]),
    .is_unsigned (uns_q),
    .rd_word     (mif.bus_rd),
    .st_data     (wdata_q),
    .ld_data     (ld_data),
    .merged      (merged)
  );

  // State register; reset abandons any access in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode: one request in flight, RESP waits for rsp_ready.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (mif.req_valid) begin
          if (!mif.req_we)              state_nxt = READ;
          else if (req_size_n == SIZE_W) state_nxt = WRITE;
          else                           state_nxt = RMW_RD;
`ifdef MMIO_MASTER_MISALIGN_TRAP_EN
          if (misaligned) state_nxt = RESP;
`endif
        end
      end
      READ:    state_nxt = RESP;
      RMW_RD:  state_nxt = WRITE;
      WRITE:   state_nxt = RESP;
      RESP:    if (mif.rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Strobes and handshakes decoded from state so reset drops them immediately.
  always_comb begin
    mif.req_ready = 1'b0;
    mif.rsp_valid = 1'b0;
    mif.bus_re    = 1'b0;
    mif.bus_we    = 1'b0;
    mif.bus_addr  = '0;
    case (state)
      IDLE:   mif.req_ready = 1'b1;
      READ:   begin mif.bus_re = 1'b1; mif.bus_addr = addr_q[ADDR_WIDTH-1:2]; end
      RMW_RD: begin mif.bus_re = 1'b1; mif.bus_addr = addr_q[ADDR_WIDTH-1:2]; end
      WRITE:  begin mif.bus_we = 1'b1; mif.bus_addr = addr_q[ADDR_WIDTH-1:2]; end
      RESP:   mif.rsp_valid = 1'b1;
      default: mif.req_ready = 1'b0;
    endcase
  end

  // Request latch, write-word build and response capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q  <= '0;
      size_q  <= SIZE_B;
      uns_q   <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      wd_q    <= '0;
`ifdef MMIO_MASTER_MISALIGN_TRAP_EN
      err_q   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (mif.req_valid) begin
            addr_q  <= req_addr_eff;
            size_q  <= req_size_n;
            uns_q   <= mif.req_unsigned;
            wdata_q <= mif.req_wdata[15:0];
            if (mif.req_we && req_size_n == SIZE_W) wd_q <= mif.req_wdata;
`ifdef MMIO_MASTER_MISALIGN_TRAP_EN
            err_q <= misaligned;
            if (misaligned) rdata_q <= ERR_RDATA;
`endif
          end
        end
        READ:    rdata_q <= ld_data;
        RMW_RD:  wd_q    <= merged;
        WRITE:   rdata_q <= '0;
        default: rdata_q <= rdata_q;
      endcase
    end
  end

endmodule
